// File: rtl/cut_bist_ctrl_if.sv
// Harness/CUT-facing bundle of the BIST controller: start/abort handshake,
// stimulus vector out, response vector in, and run status/signature.
interface cut_bist_ctrl_if #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 23
);
  logic             start_i;
  logic             abort_i;
  logic [IN_W-1:0]  x_o;
  logic [OUT_W-1:0] resp_i;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic [OUT_W-1:0] signature_o;

  // Harness/CUT side: issues commands, supplies responses, observes results.
  modport master (
    output start_i, abort_i, resp_i,
    input  x_o, busy_o, done_o, pass_o, signature_o
  );

  // Controller side.
  modport slave (
    input  start_i, abort_i, resp_i,
    output x_o, busy_o, done_o, pass_o, signature_o
  );
endinterface

// File: rtl/cut_bist_ctrl.sv
// BIST controller: drives a combinational CUT with Fibonacci-LFSR patterns,
// compacts each response into a MISR and flags whether the final signature
// equals the golden value. One pattern is applied and absorbed per cycle.
module cut_bist_ctrl #(
  parameter int              IN_W       = 28,
  parameter int              OUT_W      = 23,
  parameter int              N_PATTERNS = 1024,
  parameter logic [IN_W-1:0]  LFSR_SEED = 28'h0000001,
  parameter logic [IN_W-1:0]  LFSR_POLY = 28'h9000000,
  parameter logic [OUT_W-1:0] MISR_POLY = 23'h420000,
  parameter logic [OUT_W-1:0] GOLDEN    = 23'h0
) (
  input logic              clk,
  input logic              rst,
  cut_bist_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(N_PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PATTERNS - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED_EFF =
    (LFSR_SEED == {IN_W{1'b0}}) ? {{(IN_W-1){1'b0}}, 1'b1} : LFSR_SEED;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fibonacci LFSR step: shift left, parity of tapped bits enters at bit 0.
  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] v);
    return {v[IN_W-2:0], ^(v & LFSR_POLY)};
  endfunction

  // MISR step: same shift/feedback structure with the response folded in.
  function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] m,
                                                 input logic [OUT_W-1:0] r);
    return {m[OUT_W-2:0], ^(m & MISR_POLY)} ^ r;
  endfunction

  state_t           state_r, state_s;
  logic [IN_W-1:0]  x_r, x_s;
  logic [OUT_W-1:0] sig_r, sig_s;
  logic [OUT_W-1:0] misr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             pass_r, pass_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath update: start wins outside RUN, abort wins in RUN.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    sig_s   = sig_r;
    cnt_s   = cnt_r;
    pass_s  = pass_r;
    misr_s  = misr_next(sig_r, bus.resp_i);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          state_s = ST_RUN;
          x_s     = SEED_EFF;
          sig_s   = {OUT_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          pass_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (bus.abort_i) begin
          // Abandon the run without absorbing the current response.
          state_s = ST_IDLE;
        end else begin
          sig_s = misr_s;
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_s = ST_DONE;
            pass_s  = (misr_s == GOLDEN);
          end else begin
            x_s = lfsr_next(x_r);
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_RUN);
    done_s = (state_s == ST_DONE);
  end

  // Datapath and status registers; status flags track the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r    <= {IN_W{1'b0}};
      sig_r  <= {OUT_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      pass_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      x_r    <= x_s;
      sig_r  <= sig_s;
      cnt_r  <= cnt_s;
      pass_r <= pass_s;
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  assign bus.x_o         = x_r;
  assign bus.signature_o = sig_r;
  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;
  assign bus.pass_o      = pass_r;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Self-checking bench for cut_bist_ctrl: four instances with different
// parameter sets, checked against a pattern/signature reference model.
module tb_cut_bist_ctrl;

  localparam logic [27:0] POLY_X = 28'h9000000;
  localparam logic [22:0] POLY_M = 23'h420000;

  localparam int          NP_A = 4;
  localparam logic [27:0] SD_A = 28'h0000001;
  localparam logic [22:0] GD_A = 23'h0;
  localparam int          NP_B = 4;
  localparam logic [27:0] SD_B = 28'h0000000;
  localparam logic [22:0] GD_B = 23'hF;
  localparam int          NP_C = 4;
  localparam logic [27:0] SD_C = 28'h8000000;
  localparam logic [22:0] GD_C = 23'h0;
  localparam int          NP_D = 1024;
  localparam logic [27:0] SD_D = 28'h0000001;
  localparam logic [22:0] GD_D = 23'h0;

  logic clk;
  logic rst;
  logic        start_v [4];
  logic        abort_v [4];
  logic [22:0] resp_v  [3];
  logic [27:0] x_obs   [4];
  logic [22:0] sig_obs [4];
  logic        busy_obs[4];
  logic        done_obs[4];
  logic        pass_obs[4];
  logic [31:0] cut_key;

  int n_checks;
  int n_fails;

  cut_bist_ctrl_if #(.IN_W(28), .OUT_W(23)) if_a ();
  cut_bist_ctrl_if #(.IN_W(28), .OUT_W(23)) if_b ();
  cut_bist_ctrl_if #(.IN_W(28), .OUT_W(23)) if_c ();
  cut_bist_ctrl_if #(.IN_W(28), .OUT_W(23)) if_d ();

  cut_bist_ctrl #(.N_PATTERNS(NP_A), .LFSR_SEED(SD_A), .GOLDEN(GD_A))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  cut_bist_ctrl #(.N_PATTERNS(NP_B), .LFSR_SEED(SD_B), .GOLDEN(GD_B))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  cut_bist_ctrl #(.N_PATTERNS(NP_C), .LFSR_SEED(SD_C), .GOLDEN(GD_C))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));
  cut_bist_ctrl #(.N_PATTERNS(NP_D), .LFSR_SEED(SD_D), .GOLDEN(GD_D))
    dut_d (.clk(clk), .rst(rst), .bus(if_d));

  // Reference CUT: an arbitrary keyed combinational mixing of the inputs.
  function automatic logic [22:0] cut_model(input logic [27:0] x, input logic [31:0] key);
    return (x[22:0] & key[22:0]) ^ x[27:5] ^ {x[10:0], x[27:16]};
  endfunction

  assign if_a.start_i = start_v[0];  assign if_a.abort_i = abort_v[0];
  assign if_b.start_i = start_v[1];  assign if_b.abort_i = abort_v[1];
  assign if_c.start_i = start_v[2];  assign if_c.abort_i = abort_v[2];
  assign if_d.start_i = start_v[3];  assign if_d.abort_i = abort_v[3];
  assign if_a.resp_i = resp_v[0];
  assign if_b.resp_i = resp_v[1];
  assign if_c.resp_i = resp_v[2];
  assign if_d.resp_i = cut_model(if_d.x_o, cut_key);

  assign x_obs[0] = if_a.x_o;  assign sig_obs[0] = if_a.signature_o;
  assign x_obs[1] = if_b.x_o;  assign sig_obs[1] = if_b.signature_o;
  assign x_obs[2] = if_c.x_o;  assign sig_obs[2] = if_c.signature_o;
  assign x_obs[3] = if_d.x_o;  assign sig_obs[3] = if_d.signature_o;
  assign busy_obs[0] = if_a.busy_o;  assign done_obs[0] = if_a.done_o;  assign pass_obs[0] = if_a.pass_o;
  assign busy_obs[1] = if_b.busy_o;  assign done_obs[1] = if_b.done_o;  assign pass_obs[1] = if_b.pass_o;
  assign busy_obs[2] = if_c.busy_o;  assign done_obs[2] = if_c.done_o;  assign pass_obs[2] = if_c.pass_o;
  assign busy_obs[3] = if_d.busy_o;  assign done_obs[3] = if_d.done_o;  assign pass_obs[3] = if_d.pass_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int npat_of(input int idx);
    case (idx)
      0: return NP_A;
      1: return NP_B;
      2: return NP_C;
      default: return NP_D;
    endcase
  endfunction

  function automatic logic [22:0] golden_of(input int idx);
    case (idx)
      0: return GD_A;
      1: return GD_B;
      2: return GD_C;
      default: return GD_D;
    endcase
  endfunction

  function automatic logic [27:0] first_pattern(input int idx);
    logic [27:0] s;
    case (idx)
      0: s = SD_A;
      1: s = SD_B;
      2: s = SD_C;
      default: s = SD_D;
    endcase
    if (s == 28'h0) s = 28'h1;
    return s;
  endfunction

  // Next pattern: shift up by one, bit 0 = odd/even count of tapped ones.
  function automatic logic [27:0] ref_lfsr(input logic [27:0] v);
    return (v << 1) | 28'($countones(v & POLY_X) % 2);
  endfunction

  // Next signature: shifted register plus tap parity, then response folded in.
  function automatic logic [22:0] ref_misr(input logic [22:0] m, input logic [22:0] r);
    return ((m << 1) | 23'($countones(m & POLY_M) % 2)) ^ r;
  endfunction

  function automatic logic [22:0] resp_for(input int idx, input logic [27:0] x);
    if (idx == 3) return cut_model(x, cut_key);
    return resp_v[idx];
  endfunction

  task automatic pulse_start(input int idx);
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
  endtask

  // Full run on instance idx, optionally fresh random response every cycle
  // and a stray start pulse at RUN cycle 'poke' (negative = none).
  task automatic run_full(input int idx, input bit rand_resp, input int poke,
                          output logic [22:0] sig_out);
    logic [27:0] x;
    logic [22:0] m;
    int n;
    n = npat_of(idx);
    x = first_pattern(idx);
    m = 23'h0;
    pulse_start(idx);
    for (int k = 0; k < n; k++) begin
      check_value($sformatf("x_k%0d_i%0d", k, idx), x_obs[idx], x);
      check_value("busy_run", busy_obs[idx], 1'b1);
      if (k == 0 || k == n - 1) check_value("done_run", done_obs[idx], 1'b0);
      if (rand_resp && idx < 3) resp_v[idx] = 23'($urandom);
      if (k == poke) start_v[idx] = 1'b1;
      m = ref_misr(m, resp_for(idx, x));
      if (k < n - 1) x = ref_lfsr(x);
      tick();
      start_v[idx] = 1'b0;
    end
    check_value("busy_end", busy_obs[idx], 1'b0);
    check_value("done_end", done_obs[idx], 1'b1);
    check_value($sformatf("sig_i%0d", idx), sig_obs[idx], m);
    check_value("pass_end", pass_obs[idx], (m == golden_of(idx)));
    check_value("x_hold", x_obs[idx], x);
    sig_out = m;
  endtask

  // Run aborted while pattern j is applied; nothing of pattern j is absorbed.
  task automatic abort_run(input int idx, input int j);
    logic [27:0] x;
    logic [22:0] m;
    x = first_pattern(idx);
    m = 23'h0;
    pulse_start(idx);
    for (int k = 0; k < j; k++) begin
      m = ref_misr(m, resp_for(idx, x));
      x = ref_lfsr(x);
      tick();
    end
    abort_v[idx] = 1'b1;
    tick();
    abort_v[idx] = 1'b0;
    check_value("abort_busy", busy_obs[idx], 1'b0);
    check_value("abort_x", x_obs[idx], x);
    check_value("abort_sig", sig_obs[idx], m);
    for (int k = 0; k < 3; k++) begin
      check_value("abort_done", done_obs[idx], 1'b0);
      check_value("abort_pass", pass_obs[idx], 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [22:0] s0;
    logic [22:0] s1;
    int j;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    cut_key = $urandom;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) resp_v[i] = 23'h0;

    // Reset state of every instance.
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check_value("rst_x", x_obs[i], 28'h0);
      check_value("rst_sig", sig_obs[i], 23'h0);
      check_value("rst_busy", busy_obs[i], 1'b0);
      check_value("rst_done", done_obs[i], 1'b0);
      check_value("rst_pass", pass_obs[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Walking-one stimulus with zero response: signature 0, pass.
    run_full(0, 1'b0, -1, s0);
    check_value("zero_sig", sig_obs[0], 23'h0);
    check_value("zero_pass", pass_obs[0], 1'b1);
    // abort in DONE is ignored
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    check_value("done_abort_ign", done_obs[0], 1'b1);
    check_value("done_abort_sig", sig_obs[0], 23'h0);

    // Constant response 1: signature 0xF, fails golden 0, passes golden 0xF.
    resp_v[0] = 23'h1;
    run_full(0, 1'b0, -1, s0);
    check_value("misr_f", sig_obs[0], 23'hF);
    check_value("misr_f_fail", pass_obs[0], 1'b0);
    resp_v[1] = 23'h1;
    run_full(1, 1'b0, -1, s0);
    check_value("golden_f_pass", pass_obs[1], 1'b1);

    // High-bit seed: tap feeds back into bit 0 on the first step.
    resp_v[2] = 23'($urandom);
    run_full(2, 1'b0, -1, s0);

    // Random per-cycle responses.
    for (int r = 0; r < 4; r++) run_full(0, 1'b1, -1, s0);

    // Abort on the second RUN cycle, then an identical full run.
    resp_v[0] = 23'($urandom);
    run_full(0, 1'b0, -1, s0);
    abort_run(0, 1);
    run_full(0, 1'b0, -1, s1);
    check_value("abort_restart_sig", s1, s0);

    // Asynchronous reset between edges mid-run.
    pulse_start(0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_value("arst_x", x_obs[0], 28'h0);
    check_value("arst_sig", sig_obs[0], 23'h0);
    check_value("arst_busy", busy_obs[0], 1'b0);
    check_value("arst_done", done_obs[0], 1'b0);
    check_value("arst_pass", pass_obs[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_value("arst_idle", busy_obs[0], 1'b0);
    run_full(0, 1'b0, -1, s0);

    // Full-length run with the reference CUT, stray start mid-run,
    // restart from DONE, and a randomly placed abort.
    run_full(3, 1'b0, int'($urandom_range(1, NP_D - 2)), s0);
    run_full(3, 1'b0, -1, s1);
    check_value("restart_same_sig", s1, s0);
    j = int'($urandom_range(1, NP_D - 1));
    abort_run(3, j);
    run_full(3, 1'b0, -1, s1);
    check_value("post_abort_sig", s1, s0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
